ddr2_af_cmd_reader_0: RTL
=========================

// Module: ddr2_af_cmd_reader_0
// PURPOSE
//  Controller-side reader of the read/write address FIFO (FWFT). Pops one entry at a time,
//  decodes command/conflict/address fields, holds the decoded command stable until the
//  controller main FSM accepts it (valid/ready), and flags row conflicts. Sits between the
//  address FIFO read port and the DDR2 controller state machine, all in the clk0 domain.
// PARAMETERS
//  CHIP_ADDRESS    1   chip-select bits in entry address
//  BANK_ADDRESS    2   bank bits; NUM_BANKS = 2**BANK_ADDRESS
//  ROW_ADDRESS     13  row bits
//  COLUMN_ADDRESS  10  column bits (LSBs of entry address)
// PORTS
//  clk0              in   1   controller clock, all logic on rising edge
//  rst               in   1   asynchronous, active-low reset
//  af_addr           in   36  FIFO head: [35] conflict, [34:32] cmd, [31:0] {chip,bank,row,col}
//  af_empty          in   1   FIFO empty; af_addr valid only while low
//  ctrl_af_rden      out  1   FIFO pop strobe, one cycle per entry
//  ctrl_hold         in   1   controller busy (refresh/init); suppresses new pops
//  bank_close_all    in   1   precharge-all/refresh issued; clears open-row table
//  cmd_valid         out  1   decoded command available
//  cmd_ready         in   1   controller accepts command when cmd_valid & cmd_ready
//  cmd_wr / cmd_rd   out  1   decoded write (3'b100) / read (3'b101)
//  cmd_chip/bank/row/col out CHIP/BANK/ROW/COLUMN_ADDRESS  address fields
//  cmd_row_conflict  out  1   row open/activate required before column command
//  cmd_err           out  1   one-cycle pulse: illegal cmd popped and dropped
//  cmd_count         out  16  accepted-command counter, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset (rst low, async): all outputs 0, FSM IDLE, open-row table invalid, cmd_count 0.
//  FIFO timing: af_addr/af_empty reflect new head in the cycle after ctrl_af_rden.
//  Pop condition P = !af_empty & !ctrl_hold & (state==IDLE | (cmd_valid & cmd_ready)).
//  ctrl_af_rden = P (combinational from registered state + inputs); never asserted when af_empty.
//  On P: fields of af_addr registered at that edge; latency pop -> cmd_valid = 1 cycle.
//  FSM: IDLE --P&legal--> VALID; IDLE --P&illegal--> IDLE with cmd_err pulse next cycle.
//       VALID: outputs held stable while !cmd_ready. On accept: cmd_count+1;
//       if P&legal stay VALID with new fields (back-to-back, 1 cmd/cycle);
//       if P&illegal -> IDLE + cmd_err; else -> IDLE, cmd_valid drops next cycle.
//  Legal cmds: 3'b100 write, 3'b101 read; all others illegal, never reach cmd_valid.
//  ctrl_hold only blocks new pops; a command already in VALID stays presented.
//  FIFO empty in VALID after accept: cmd_valid low next cycle, no pop.
//  Reset mid-operation: held command discarded; FIFO entry already popped is lost (by design).
//  Field slicing: col=[COLUMN-1:0], row above col, bank above row, chip above bank.
// CONFIGURATION
//  AF_BANK_TRACK_EN defined: per-bank open-row table (NUM_BANKS x ROW_ADDRESS + valid bit).
//   cmd_row_conflict = !valid[bank] | open_row[bank]!=row, computed at pop from af_addr.
//   On accept: valid[bank]<=1, open_row[bank]<=row. bank_close_all clears all valid bits;
//   if coincident with accept, clear wins and the accepted bank is also left invalid.
//  Not defined: no table; cmd_row_conflict = af_addr[35] registered at pop; bank_close_all ignored.
// TESTING
//  Reset then single entry {1'b0,3'b100,bank 1,row 5,col 8}, ready=1 -> rden 1 cycle,
//   cmd_valid+cmd_wr next cycle with fields 1/5/8, cmd_count=1.
//  Four reads queued, cmd_ready held low 3 cycles -> one rden only, fields stable; then
//   ready=1 -> four consecutive accepts on consecutive cycles, cmd_count=4.
//  Entry with cmd 3'b011 -> popped, cmd_err pulse 1 cycle, cmd_valid stays 0, count unchanged.
//  ctrl_hold=1 with non-empty FIFO -> rden never asserted; release -> pop next cycle.
//  AF_BANK_TRACK_EN: rd bank0 row7, rd bank0 row7, rd bank0 row9 -> conflict 1,0,1;
//   bank_close_all pulse then rd bank0 row9 -> conflict 1. Without macro: conflict = bit35.
//  Async rst low while VALID -> cmd_valid, rden, count to 0 immediately, no clock edge needed.

Source files
------------

// File: rtl/ddr2_af_cmd_reader_0_if.sv
// ddr2_af_cmd_reader_0_if: address-FIFO read port plus decoded command handshake.
// slave = command reader view, master = FIFO/controller view.
interface ddr2_af_cmd_reader_0_if #(
    parameter int CHIP_ADDRESS   = 1,
    parameter int BANK_ADDRESS   = 2,
    parameter int ROW_ADDRESS    = 13,
    parameter int COLUMN_ADDRESS = 10
);
    logic [35:0]               af_addr;
    logic                      af_empty;
    logic                      ctrl_af_rden;
    logic                      ctrl_hold;
    logic                      bank_close_all;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_wr;
    logic                      cmd_rd;
    logic [CHIP_ADDRESS-1:0]   cmd_chip;
    logic [BANK_ADDRESS-1:0]   cmd_bank;
    logic [ROW_ADDRESS-1:0]    cmd_row;
    logic [COLUMN_ADDRESS-1:0] cmd_col;
    logic                      cmd_row_conflict;
    logic                      cmd_err;
    logic [15:0]               cmd_count;

    modport slave (
        input  af_addr, af_empty, ctrl_hold, bank_close_all, cmd_ready,
        output ctrl_af_rden, cmd_valid, cmd_wr, cmd_rd, cmd_chip, cmd_bank, cmd_row,
               cmd_col, cmd_row_conflict, cmd_err, cmd_count
    );
    modport master (
        output af_addr, af_empty, ctrl_hold, bank_close_all, cmd_ready,
        input  ctrl_af_rden, cmd_valid, cmd_wr, cmd_rd, cmd_chip, cmd_bank, cmd_row,
               cmd_col, cmd_row_conflict, cmd_err, cmd_count
    );
endinterface

// File: rtl/ddr2_af_cmd_reader_0.sv
// ddr2_af_cmd_reader_0: pops FWFT address FIFO, decodes and holds commands under valid/ready.
// Define AF_BANK_TRACK_EN for per-bank open-row conflict tracking; otherwise conflict = af_addr[35].
module ddr2_af_cmd_reader_0 #(
    parameter int CHIP_ADDRESS   = 1,
    parameter int BANK_ADDRESS   = 2,
    parameter int ROW_ADDRESS    = 13,
    parameter int COLUMN_ADDRESS = 10
) (
    input logic                  clk0,
    input logic                  rst,
    ddr2_af_cmd_reader_0_if.slave af
);
    localparam int ROW_LO  = COLUMN_ADDRESS;
    localparam int BANK_LO = ROW_LO + ROW_ADDRESS;
    localparam int CHIP_LO = BANK_LO + BANK_ADDRESS;

    typedef enum logic {IDLE, VALID} state_t;

    state_t                    state_q, state_d;
    logic                      wr_q, rd_q, conf_q, err_q;
    logic [CHIP_ADDRESS-1:0]   chip_q;
    logic [BANK_ADDRESS-1:0]   bank_q;
    logic [ROW_ADDRESS-1:0]    row_q;
    logic [COLUMN_ADDRESS-1:0] col_q;
    logic [15:0]               count_q;
    logic [2:0]                cmd_n;
    logic [BANK_ADDRESS-1:0]   bank_n;
    logic [ROW_ADDRESS-1:0]    row_n;
    logic                      legal, accept, pop, conf_n;

    assign cmd_n  = af.af_addr[34:32];
    assign bank_n = af.af_addr[BANK_LO +: BANK_ADDRESS];
    assign row_n  = af.af_addr[ROW_LO +: ROW_ADDRESS];
    assign legal  = cmd_n[2:1] == 2'b10;
    assign accept = (state_q == VALID) && af.cmd_ready;
    // Gated by rst so the pop strobe drops the instant reset is asserted.
    assign pop    = rst && !af.af_empty && !af.ctrl_hold && ((state_q == IDLE) || accept);

    always_comb begin
        state_d = pop ? (legal ? VALID : IDLE) : (accept ? IDLE : state_q);
    end

`ifdef AF_BANK_TRACK_EN
    localparam int NUM_BANKS = 2 ** BANK_ADDRESS;
    logic [NUM_BANKS-1:0]   open_vld_q, open_vld_d;
    logic [ROW_ADDRESS-1:0] open_row_q [NUM_BANKS];
    logic                   fwd;

    // Compare against the table as it will stand after this edge's accept/close.
    always_comb begin
        open_vld_d = open_vld_q;
        if (accept) open_vld_d[bank_q] = 1'b1;
        if (af.bank_close_all) open_vld_d = '0;
    end
    assign fwd    = accept && (bank_q == bank_n);
    assign conf_n = !open_vld_d[bank_n] || ((fwd ? row_q : open_row_q[bank_n]) != row_n);

    always_ff @(posedge clk0 or negedge rst) begin
        if (!rst) open_vld_q <= '0;
        else open_vld_q <= open_vld_d;
    end
    always_ff @(posedge clk0) begin
        if (accept) open_row_q[bank_q] <= row_q;
    end
`else
    assign conf_n = af.af_addr[35];
`endif

    always_ff @(posedge clk0 or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            conf_q  <= 1'b0;
            err_q   <= 1'b0;
            chip_q  <= '0;
            bank_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= pop && !legal;
            if (accept) count_q <= count_q + 16'd1;
            if (pop && legal) begin
                wr_q   <= !cmd_n[0];
                rd_q   <= cmd_n[0];
                conf_q <= conf_n;
                chip_q <= af.af_addr[CHIP_LO +: CHIP_ADDRESS];
                bank_q <= bank_n;
                row_q  <= row_n;
                col_q  <= af.af_addr[COLUMN_ADDRESS-1:0];
            end
        end
    end

    assign af.ctrl_af_rden     = pop;
    assign af.cmd_valid        = state_q == VALID;
    assign af.cmd_wr           = wr_q;
    assign af.cmd_rd           = rd_q;
    assign af.cmd_chip         = chip_q;
    assign af.cmd_bank         = bank_q;
    assign af.cmd_row          = row_q;
    assign af.cmd_col          = col_q;
    assign af.cmd_row_conflict = conf_q;
    assign af.cmd_err          = err_q;
    assign af.cmd_count        = count_q;
endmodule
